// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit FND time display.
// Font codes are active-low with bit7 as the decimal point.
package fnd_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam int DP_BIT = 7;

  localparam logic [7:0] FONT_0 = 8'hC0;
  localparam logic [7:0] FONT_1 = 8'hF9;
  localparam logic [7:0] FONT_2 = 8'hA4;
  localparam logic [7:0] FONT_3 = 8'hB0;
  localparam logic [7:0] FONT_4 = 8'h99;
  localparam logic [7:0] FONT_5 = 8'h92;
  localparam logic [7:0] FONT_6 = 8'h82;
  localparam logic [7:0] FONT_7 = 8'hF8;
  localparam logic [7:0] FONT_8 = 8'h80;
  localparam logic [7:0] FONT_9 = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  localparam logic [3:0] COM_D0  = 4'b1110;
  localparam logic [3:0] COM_D1  = 4'b1101;
  localparam logic [3:0] COM_D2  = 4'b1011;
  localparam logic [3:0] COM_D3  = 4'b0111;
  localparam logic [3:0] COM_OFF = 4'b1111;

  function automatic logic [3:0] com_of(
    input digit_idx_t idx
  );
    logic [3:0] c;
    c = COM_OFF;
    unique case (idx)
      2'd0: c = COM_D0;
      2'd1: c = COM_D1;
      2'd2: c = COM_D2;
      2'd3: c = COM_D3;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// BCD digit to active-low 7-segment pattern (g..a).
// Codes above 9 blank the digit.
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = FONT_BLANK[6:0];
    case (digit)
      4'd0: seg = FONT_0[6:0];
      4'd1: seg = FONT_1[6:0];
      4'd2: seg = FONT_2[6:0];
      4'd3: seg = FONT_3[6:0];
      4'd4: seg = FONT_4[6:0];
      4'd5: seg = FONT_5[6:0];
      4'd6: seg = FONT_6[6:0];
      4'd7: seg = FONT_7[6:0];
      4'd8: seg = FONT_8[6:0];
      4'd9: seg = FONT_9[6:0];
      default: seg = FONT_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/fnd_time_display.sv
// Multiplexed 4-digit FND showing SS.cc or HH.MM with a blinking dot.
// Define FND_LEADING_ZERO_BLANK_EN to blank a leading zero on digit3.
module fnd_time_display
  import fnd_pkg::*;
#(
  parameter int COUNT_SCAN = 100_000,
  parameter int MSEC_MAX   = 100,
  parameter int SEC_MAX    = 60,
  parameter int MIN_MAX    = 60,
  parameter int HOUR_MAX   = 24,
  localparam int MW = $clog2(MSEC_MAX),
  localparam int SW = $clog2(SEC_MAX),
  localparam int NW = $clog2(MIN_MAX),
  localparam int HW = $clog2(HOUR_MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_disp_sel,
  input  logic [MW-1:0] i_msec,
  input  logic [SW-1:0] i_sec,
  input  logic [NW-1:0] i_min,
  input  logic [HW-1:0] i_hour,
  output logic [3:0]    o_fnd_com,
  output logic [7:0]    o_fnd_font
);

  localparam int CW = (COUNT_SCAN > 1) ? $clog2(COUNT_SCAN) : 1;
  localparam int RW = (MW > NW) ? MW : NW;
  localparam int LW = (SW > HW) ? SW : HW;

  logic [CW-1:0] cnt;
  logic          scan_tick;
  digit_idx_t    idx;
  digit_idx_t    idx_n;
  logic          wrap;

  logic          snap_sel;
  logic [MW-1:0] snap_msec;
  logic [SW-1:0] snap_sec;
  logic [NW-1:0] snap_min;
  logic [HW-1:0] snap_hour;

  logic          n_sel;
  logic [MW-1:0] n_msec;
  logic [SW-1:0] n_sec;
  logic [NW-1:0] n_min;
  logic [HW-1:0] n_hour;

  logic [RW-1:0] right;
  logic [LW-1:0] left;
  logic [3:0]    val;
  logic [6:0]    seg;
  logic          dp;
  logic [7:0]    font_n;

  assign scan_tick = (cnt == CW'(COUNT_SCAN - 1));
  assign idx_n     = idx + 2'd1;
  assign wrap      = scan_tick && (idx == 2'd3);

  // Outputs are computed for the digit about to be shown, so the first
  // digit of a frame already sees the values captured on that same edge.
  always_comb begin
    n_sel  = wrap ? i_disp_sel : snap_sel;
    n_msec = wrap ? i_msec : snap_msec;
    n_sec  = wrap ? i_sec : snap_sec;
    n_min  = wrap ? i_min : snap_min;
    n_hour = wrap ? i_hour : snap_hour;
  end

  always_comb begin
    right = n_sel ? RW'(n_min) : RW'(n_msec);
    left  = n_sel ? LW'(n_hour) : LW'(n_sec);
    val   = '0;
    unique case (idx_n)
      2'd0: val = 4'(right % RW'(10));
      2'd1: val = 4'((right / RW'(10)) % RW'(10));
      2'd2: val = 4'(left % LW'(10));
      2'd3: val = 4'((left / LW'(10)) % LW'(10));
    endcase
  end

  fnd_seg_decoder u_dec (
    .digit(val),
    .seg  (seg)
  );

  always_comb begin
    dp     = !((idx_n == 2'd2) && (n_msec < MW'(MSEC_MAX / 2)));
    font_n = {dp, seg};
`ifdef FND_LEADING_ZERO_BLANK_EN
    if ((idx_n == 2'd3) && (val == 4'd0)) begin
      font_n = FONT_BLANK;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (scan_tick) begin
      cnt <= '0;
      idx <= idx_n;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_sel  <= 1'b0;
      snap_msec <= '0;
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hour <= '0;
    end else if (wrap) begin
      snap_sel  <= i_disp_sel;
      snap_msec <= i_msec;
      snap_sec  <= i_sec;
      snap_min  <= i_min;
      snap_hour <= i_hour;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_fnd_com  <= COM_OFF;
      o_fnd_font <= FONT_BLANK;
    end else if (scan_tick) begin
      o_fnd_com  <= com_of(idx_n);
      o_fnd_font <= font_n;
    end
  end

endmodule

// File: tb/tb_fnd_time_display.sv
// Directed bench for fnd_time_display with a short scan slot.
// Each scenario task checks its own expected segment patterns.
module tb_fnd_time_display;

  logic       clk;
  logic       reset;
  logic       i_disp_sel;
  logic [6:0] i_msec;
  logic [5:0] i_sec;
  logic [5:0] i_min;
  logic [4:0] i_hour;
  logic [3:0] o_fnd_com;
  logic [7:0] o_fnd_font;

  int errors = 0;
  int checks = 0;

  logic [7:0] frame[4];
  logic [3:0] coms[4];

  fnd_time_display #(
    .COUNT_SCAN(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_disp_sel(i_disp_sel),
    .i_msec    (i_msec),
    .i_sec     (i_sec),
    .i_min     (i_min),
    .i_hour    (i_hour),
    .o_fnd_com (o_fnd_com),
    .o_fnd_font(o_fnd_font)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_com(input logic [3:0] c, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (o_fnd_com !== c && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (o_fnd_com !== c) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: com=%b want=%b", tag, o_fnd_com, c);
    end
  endtask

  // Waits for the start of a fresh frame, then samples all four slots.
  task automatic capture_frame(input string tag);
    int n;
    n = 0;
    while (o_fnd_com === 4'b1110 && n < 64) begin
      @(negedge clk);
      n++;
    end
    wait_com(4'b1110, tag);
    for (int k = 0; k < 4; k++) begin
      frame[k] = o_fnd_font;
      coms[k]  = o_fnd_com;
      if (k < 3) repeat (4) @(negedge clk);
    end
  endtask

  task automatic check_frame(
    input string      tag,
    input logic [7:0] e0,
    input logic [7:0] e1,
    input logic [7:0] e2,
    input logic [7:0] e3
  );
    logic [7:0] exp_f[4];
    logic [3:0] exp_c[4];
    exp_f = '{e0, e1, e2, e3};
    exp_c = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    capture_frame(tag);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (frame[k] !== exp_f[k]) begin
        errors++;
        $display("FAIL %s digit%0d font=%h want=%h",
                 tag, k, frame[k], exp_f[k]);
      end
      checks++;
      if (coms[k] !== exp_c[k]) begin
        errors++;
        $display("FAIL %s digit%0d com=%b want=%b",
                 tag, k, coms[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (o_fnd_com !== 4'b1111) begin
      errors++;
      $display("FAIL reset_com got=%b want=1111", o_fnd_com);
    end
    checks++;
    if (o_fnd_font !== 8'hFF) begin
      errors++;
      $display("FAIL reset_font got=%h want=ff", o_fnd_font);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_fnd_com !== 4'b1111) begin
      errors++;
      $display("FAIL pre_tick_com got=%b want=1111", o_fnd_com);
    end
    @(negedge clk);
    checks++;
    if (o_fnd_com !== 4'b1101) begin
      errors++;
      $display("FAIL first_tick_com got=%b want=1101", o_fnd_com);
    end
    checks++;
    if (o_fnd_font !== 8'hC0) begin
      errors++;
      $display("FAIL first_tick_font got=%h want=c0", o_fnd_font);
    end
  endtask

  task automatic test_sec_msec;
    i_disp_sel = 1'b0;
    i_sec      = 6'd37;
    i_msec     = 7'd5;
    check_frame("sec_msec", 8'h92, 8'hC0, 8'h78, 8'hB0);
  endtask

  task automatic test_dot;
    i_msec = 7'd50;
    check_frame("dot_50", 8'hC0, 8'h92, 8'hF8, 8'hB0);
    i_msec = 7'd49;
    check_frame("dot_49", 8'h90, 8'h99, 8'h78, 8'hB0);
  endtask

  task automatic test_hour_min;
    i_disp_sel = 1'b1;
    i_hour     = 5'd23;
    i_min      = 6'd59;
    i_msec     = 7'd10;
    check_frame("hm_dot", 8'h90, 8'h92, 8'h30, 8'hA4);
    i_msec = 7'd70;
    check_frame("hm_nodot", 8'h90, 8'h92, 8'hB0, 8'hA4);
  endtask

  task automatic test_mid_frame;
    i_disp_sel = 1'b0;
    i_sec      = 6'd37;
    i_msec     = 7'd5;
    capture_frame("mid_prep");
    wait_com(4'b1110, "mid_d0");
    repeat (4) @(negedge clk);
    i_sec      = 6'd12;
    i_disp_sel = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (o_fnd_font !== 8'h78 || o_fnd_com !== 4'b1011) begin
      errors++;
      $display("FAIL mid_d2 font=%h com=%b want=78/1011",
               o_fnd_font, o_fnd_com);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (o_fnd_font !== 8'hB0 || o_fnd_com !== 4'b0111) begin
      errors++;
      $display("FAIL mid_d3 font=%h com=%b want=b0/0111",
               o_fnd_font, o_fnd_com);
    end
    i_disp_sel = 1'b0;
    check_frame("mid_next", 8'h92, 8'hC0, 8'h24, 8'hF9);
  endtask

  task automatic test_leading_zero;
    logic [7:0] d3;
`ifdef FND_LEADING_ZERO_BLANK_EN
    d3 = 8'hFF;
`else
    d3 = 8'hC0;
`endif
    i_disp_sel = 1'b1;
    i_hour     = 5'd5;
    i_min      = 6'd0;
    i_msec     = 7'd0;
    check_frame("lead_zero", 8'hC0, 8'hC0, 8'h12, d3);
  endtask

  task automatic test_reset_mid;
    wait_com(4'b1011, "rst_mid_wait");
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (o_fnd_com !== 4'b1111 || o_fnd_font !== 8'hFF) begin
      errors++;
      $display("FAIL rst_mid com=%b font=%h want=1111/ff",
               o_fnd_com, o_fnd_font);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (o_fnd_com !== 4'b1101) begin
      errors++;
      $display("FAIL rst_mid_restart com=%b want=1101", o_fnd_com);
    end
  endtask

  initial begin
    reset      = 1'b1;
    i_disp_sel = 1'b0;
    i_msec     = '0;
    i_sec      = '0;
    i_min      = '0;
    i_hour     = '0;
    test_reset();
    test_sec_msec();
    test_dot();
    test_hour_min();
    test_mid_frame();
    test_leading_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fnd_time_display.md
Name: fnd_time_display

Overview:
- Downstream consumer of the stopwatch/watch time outputs (msec, sec, min, hour).
- Drives a 4-digit common-anode 7-segment display (FND) by time-multiplexed digit scanning.
- Shows either SS.cc (sec.msec) or HH.MM (hour.min) with a 1 Hz blinking separator dot.
- Snapshots inputs once per scan frame so a frame never mixes old and new time values.

Parameters:
- COUNT_SCAN, 100_000: clk cycles per digit slot (1 kHz digit rate at 100 MHz).
- MSEC_MAX, 100: centisecond modulus. Also sets input width.
- SEC_MAX, 60: second modulus. Also sets input width.
- MIN_MAX, 60: minute modulus. Also sets input width.
- HOUR_MAX, 24: hour modulus. Also sets input width.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- i_disp_sel, input, 1: 0 = sec.msec, 1 = hour.min.
- i_msec, input, $clog2(MSEC_MAX): centiseconds.
- i_sec, input, $clog2(SEC_MAX): seconds.
- i_min, input, $clog2(MIN_MAX): minutes.
- i_hour, input, $clog2(HOUR_MAX): hours.
- o_fnd_com, output, 4: digit enables, active-low, one-hot-zero. Bit0 = rightmost digit.
- o_fnd_font, output, 8: segments, active-low. Bit7 = dp, bits6:0 = g,f,e,d,c,b,a.

Behaviour:
- Reset values: all counters 0, all snapshot registers 0, o_fnd_com = 4'b1111 (all digits off), o_fnd_font = 8'hFF.
- Scan counter: counts 0..COUNT_SCAN-1 and wraps. A one-cycle scan_tick is asserted at the wrap.
- Digit index: 2-bit, increments on each scan_tick, order 0→1→2→3→0.
- Snapshot: on a scan_tick where the digit index wraps 3→0, i_disp_sel, i_msec, i_sec, i_min and i_hour are all captured together. All four digits of a frame come from the same snapshot.
- Field selection:
  - Right field = msec when sel = 0, min when sel = 1.
  - Left field = sec when sel = 0, hour when sel = 1.
- Digit mapping:
  - digit0 = right % 10
  - digit1 = (right / 10) % 10
  - digit2 = left % 10
  - digit3 = (left / 10) % 10
  - Every digit value is therefore 0..9 regardless of input range.
- Font table (active-low, dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Any other code gives FF.
- Dot: lit (bit7 = 0) only on digit2, and only while the snapshot msec < MSEC_MAX/2. This holds in both display modes and gives a 1 Hz, 50% blink. All other digits have dp off.
- Outputs are registered. o_fnd_com and o_fnd_font update in the cycle after scan_tick and never disagree about which digit is active.
- Latency: an input change appears on the display within 4*COUNT_SCAN + 2 cycles.
- Reset asserted mid-scan: outputs go to their reset values immediately (asynchronously). After reset is released, the first scan_tick selects digit1.
- Mode change mid-frame: ignored until the next frame snapshot.

Optional Feature:
- Macro FND_LEADING_ZERO_BLANK_EN.
  - Defined: digit3 shows all segments off (font FF) when its value is 0, in both modes.
  - Undefined: digit3 always shows its numeral, including 0 (C0).

Decomposition:
- Package fnd_pkg holds:
  - the 10-entry font constants, FONT_BLANK = 8'hFF, and the DP bit index;
  - COM encodings per digit index (1110, 1101, 1011, 0111) and COM_OFF = 1111;
  - the 2-bit digit-index typedef.
- Sub-module fnd_seg_decoder: combinational 4-bit digit in, 7-bit font out. Instantiated once, fed by the selected digit.

Test Plan (all scenarios use COUNT_SCAN = 4):
- Reset held: o_fnd_com = 1111 and o_fnd_font = FF. Release reset → after the first scan_tick plus 1 cycle, o_fnd_com = 1101.
- sel = 0, sec = 37, msec = 5, cycle through a full frame: digit0 = 92, digit1 = C0, digit2 = 78 (7 with dp lit), digit3 = B0.
- Same stimulus with msec = 50: digit2 = F8 (dp off). msec = 49 → digit2 = 78.
- sel = 1, hour = 23, min = 59: digit0 = 90, digit1 = 92, digit2 = 30 or B0 depending on msec, digit3 = A4.
- Change sec from 37 to 12 while the digit index = 1: digits 2 and 3 of the current frame still show 7 and 3. The next frame shows 2 and 1.
- hour = 5, sel = 1: digit3 = FF with FND_LEADING_ZERO_BLANK_EN defined, C0 without it. Separately, assert reset mid-slot → o_fnd_com = 1111 in the same cycle.
